// File: rtl/error_inject_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : error_inject_sequencer
// Purpose  : Replays a programmable table of error-injection entries to an
//            injector. Each entry carries a type, site mask, duration and a
//            post-injection gap. The table is replayed for a configurable
//            number of loops, or until stopped when the loop count is 0.
//            Only one injection is in flight at a time. The sequencer issues
//            a one-cycle enable pulse and then waits on the injector's
//            active status.
// Ports    : clk, rst_n (async, active low)
//            i_tbl_wr_*        table programming (accepted in IDLE only)
//            i_seq_start/stop  campaign control
//            i_seq_num_entries, i_seq_loop_count  sampled on start
//            i_inject_active   injector busy status
//            o_inject_*        injector control (enable pulse + entry fields)
//            o_seq_busy/done/error, o_cur_entry, o_loops_done  status
// Revision : 1.0  initial release
// ============================================================================
module error_inject_sequencer #(
  parameter int NUM_ENTRIES      = 8,
  parameter int NUM_INJECT_SITES = 16,
  parameter int ACK_TIMEOUT      = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_tbl_wr_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0]    i_tbl_wr_idx,
  input  logic [3:0]                        i_tbl_wr_type,
  input  logic [NUM_INJECT_SITES-1:0]       i_tbl_wr_sites,
  input  logic [15:0]                       i_tbl_wr_duration,
  input  logic [15:0]                       i_tbl_wr_gap,
  input  logic                              i_seq_start,
  input  logic                              i_seq_stop,
  input  logic [$clog2(NUM_ENTRIES):0]      i_seq_num_entries,
  input  logic [7:0]                        i_seq_loop_count,
  input  logic                              i_inject_active,
  output logic                              o_inject_enable,
  output logic [3:0]                        o_inject_type,
  output logic [NUM_INJECT_SITES-1:0]       o_inject_site_sel,
  output logic [15:0]                       o_inject_duration,
  output logic                              o_seq_busy,
  output logic                              o_seq_done,
  output logic                              o_seq_error,
  output logic [$clog2(NUM_ENTRIES)-1:0]    o_cur_entry,
  output logic [7:0]                        o_loops_done
);

  localparam int c_IW = $clog2(NUM_ENTRIES);
  localparam int c_CW = c_IW + 1;
  localparam int c_TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_WAIT_END = 3'd3,
    S_GAP      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t r_state, w_state_nxt;

  // Campaign table
  logic [3:0]                  r_tbl_type  [NUM_ENTRIES];
  logic [NUM_INJECT_SITES-1:0] r_tbl_sites [NUM_ENTRIES];
  logic [15:0]                 r_tbl_dur   [NUM_ENTRIES];
  logic [15:0]                 r_tbl_gap   [NUM_ENTRIES];

  // Entry in progress and campaign bookkeeping
  logic [3:0]                  r_type;
  logic [NUM_INJECT_SITES-1:0] r_sites;
  logic [15:0]                 r_dur;
  logic [15:0]                 r_gap;
  logic [c_IW-1:0]             r_cur;
  logic [c_CW-1:0]             r_num;
  logic [7:0]                  r_loop_cnt;
  logic [7:0]                  r_loops;
  logic                        r_err;
  logic                        r_stop_pend;
  logic [c_TW-1:0]             r_ack_cnt;
  logic [15:0]                 r_gap_cnt;

  // Next-entry decision, shared by ISSUE (zero duration), WAIT_END and GAP
  logic [c_CW-1:0]             w_cur_p1;
  logic                        w_last;
  logic [7:0]                  w_loops_p1;
  logic                        w_finish;
  logic [c_IW-1:0]             w_adv_idx;
  state_t                      w_adv_state;

  logic                        w_start;
  logic                        w_bad_start;
  logic                        w_adv;
  logic                        w_timeout;
  logic                        w_gap_load;
  logic                        w_num_ok;

  always_comb begin
    w_cur_p1    = {1'b0, r_cur} + c_CW'(1);
    w_last      = (w_cur_p1 >= r_num);
    w_loops_p1  = (r_loops == 8'hFF) ? 8'hFF : r_loops + 8'd1;
    w_finish    = w_last && (r_loop_cnt != 8'd0) && (w_loops_p1 == r_loop_cnt);
    w_adv_idx   = w_last ? '0 : r_cur + c_IW'(1);
    w_adv_state = w_finish ? S_DONE : S_ISSUE;
    w_num_ok    = (i_seq_num_entries != '0) &&
                  (i_seq_num_entries <= c_CW'(NUM_ENTRIES));
  end

  // Next-state logic and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_bad_start = 1'b0;
    w_adv       = 1'b0;
    w_timeout   = 1'b0;
    w_gap_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A simultaneous stop suppresses the start entirely
        if (i_seq_start && !i_seq_stop) begin
          if (w_num_ok) begin
            w_start     = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_bad_start = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (i_seq_stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_dur == 16'd0) begin
          w_adv       = 1'b1;
          w_state_nxt = w_adv_state;
        end else begin
          w_state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (i_inject_active) begin
          w_state_nxt = S_WAIT_END;
        end else if (r_ack_cnt == c_TW'(ACK_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_END: begin
        if (!i_inject_active) begin
          if (r_stop_pend || i_seq_stop) begin
            w_state_nxt = S_IDLE;
          end else if (r_gap != 16'd0) begin
            w_gap_load  = 1'b1;
            w_state_nxt = S_GAP;
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = w_adv_state;
          end
        end
      end
      S_GAP: begin
        if (i_seq_stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_gap_cnt <= 16'd1) begin
          w_adv       = 1'b1;
          w_state_nxt = w_adv_state;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_tbl_type[i]  <= '0;
        r_tbl_sites[i] <= '0;
        r_tbl_dur[i]   <= '0;
        r_tbl_gap[i]   <= '0;
      end
      r_type      <= '0;
      r_sites     <= '0;
      r_dur       <= '0;
      r_gap       <= '0;
      r_cur       <= '0;
      r_num       <= '0;
      r_loop_cnt  <= '0;
      r_loops     <= '0;
      r_err       <= 1'b0;
      r_stop_pend <= 1'b0;
      r_ack_cnt   <= '0;
      r_gap_cnt   <= '0;
    end else begin
      // Table read for a same-cycle start sees the pre-write contents
      if (r_state == S_IDLE && i_tbl_wr_en) begin
        r_tbl_type[i_tbl_wr_idx]  <= i_tbl_wr_type;
        r_tbl_sites[i_tbl_wr_idx] <= i_tbl_wr_sites;
        r_tbl_dur[i_tbl_wr_idx]   <= i_tbl_wr_duration;
        r_tbl_gap[i_tbl_wr_idx]   <= i_tbl_wr_gap;
      end

      if (w_start) begin
        r_num      <= i_seq_num_entries;
        r_loop_cnt <= i_seq_loop_count;
        r_loops    <= '0;
        r_cur      <= '0;
        r_type     <= r_tbl_type[0];
        r_sites    <= r_tbl_sites[0];
        r_dur      <= r_tbl_dur[0];
        r_gap      <= r_tbl_gap[0];
      end else if (w_adv) begin
        r_cur <= w_adv_idx;
        if (w_last) r_loops <= w_loops_p1;
        if (w_adv_state == S_ISSUE) begin
          r_type  <= r_tbl_type[w_adv_idx];
          r_sites <= r_tbl_sites[w_adv_idx];
          r_dur   <= r_tbl_dur[w_adv_idx];
          r_gap   <= r_tbl_gap[w_adv_idx];
        end
      end else if (r_state != S_IDLE && w_state_nxt == S_IDLE) begin
        r_cur   <= '0;
        r_type  <= '0;
        r_sites <= '0;
        r_dur   <= '0;
        r_gap   <= '0;
      end

      if (w_start)                       r_err <= 1'b0;
      else if (w_bad_start || w_timeout) r_err <= 1'b1;

      // A stop during an in-flight injection is remembered until it drains
      if (w_state_nxt == S_IDLE)
        r_stop_pend <= 1'b0;
      else if ((r_state == S_WAIT_ACK || r_state == S_WAIT_END) && i_seq_stop)
        r_stop_pend <= 1'b1;

      if (r_state == S_WAIT_ACK && w_state_nxt == S_WAIT_ACK)
        r_ack_cnt <= r_ack_cnt + c_TW'(1);
      else
        r_ack_cnt <= '0;

      if (w_gap_load)            r_gap_cnt <= r_gap;
      else if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt - 16'd1;
    end
  end

  assign o_inject_enable   = (r_state == S_ISSUE) && (r_dur != 16'd0) && !i_seq_stop;
  assign o_inject_type     = r_type;
  assign o_inject_site_sel = r_sites;
  assign o_inject_duration = r_dur;
  assign o_seq_busy        = (r_state != S_IDLE);
  assign o_seq_done        = (r_state == S_DONE);
  assign o_seq_error       = r_err;
  assign o_cur_entry       = r_cur;
  assign o_loops_done      = r_loops;

endmodule
`default_nettype wire

// File: tb/tb_error_inject_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_error_inject_sequencer
// Purpose  : Self-checking bench for error_inject_sequencer. Includes a
//            behavioural injector. A campaign-level model predicts every
//            enable pulse, giving its fields and cycle, and predicts the
//            completion cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_error_inject_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_tbl_wr_en = 1'b0;
  logic [2:0]  i_tbl_wr_idx = '0;
  logic [3:0]  i_tbl_wr_type = '0;
  logic [15:0] i_tbl_wr_sites = '0;
  logic [15:0] i_tbl_wr_duration = '0;
  logic [15:0] i_tbl_wr_gap = '0;
  logic        i_seq_start = 1'b0;
  logic        i_seq_stop = 1'b0;
  logic [3:0]  i_seq_num_entries = '0;
  logic [7:0]  i_seq_loop_count = '0;
  logic        i_inject_active;
  logic        o_inject_enable;
  logic [3:0]  o_inject_type;
  logic [15:0] o_inject_site_sel;
  logic [15:0] o_inject_duration;
  logic        o_seq_busy, o_seq_done, o_seq_error;
  logic [2:0]  o_cur_entry;
  logic [7:0]  o_loops_done;

  error_inject_sequencer #(.NUM_ENTRIES(8), .NUM_INJECT_SITES(16), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_tbl_wr_en(i_tbl_wr_en), .i_tbl_wr_idx(i_tbl_wr_idx), .i_tbl_wr_type(i_tbl_wr_type),
    .i_tbl_wr_sites(i_tbl_wr_sites), .i_tbl_wr_duration(i_tbl_wr_duration),
    .i_tbl_wr_gap(i_tbl_wr_gap), .i_seq_start(i_seq_start), .i_seq_stop(i_seq_stop),
    .i_seq_num_entries(i_seq_num_entries), .i_seq_loop_count(i_seq_loop_count),
    .i_inject_active(i_inject_active), .o_inject_enable(o_inject_enable),
    .o_inject_type(o_inject_type), .o_inject_site_sel(o_inject_site_sel),
    .o_inject_duration(o_inject_duration), .o_seq_busy(o_seq_busy),
    .o_seq_done(o_seq_done), .o_seq_error(o_seq_error), .o_cur_entry(o_cur_entry),
    .o_loops_done(o_loops_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int start_cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Injector: active from the cycle after an enable, for 'duration' cycles
  logic        stuck = 1'b0;
  logic [15:0] act;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            act <= '0;
    else if (o_inject_enable && !stuck)    act <= o_inject_duration;
    else if (act != 16'd0)                 act <= act - 16'd1;
  end
  assign i_inject_active = (act != 16'd0);

  typedef struct {
    logic [3:0]  t;
    logic [15:0] s;
    logic [15:0] d;
    int          c;
  } exp_t;
  exp_t exp_q[$];
  int   done_q[$];
  exp_t mon_e;

  // Software view of the table
  logic [3:0]  m_type  [8];
  logic [15:0] m_sites [8];
  logic [15:0] m_dur   [8];
  logic [15:0] m_gap   [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_inject_enable) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_enable", 64'(cyc - start_cyc), 64'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("enable", {o_inject_type, o_inject_site_sel, o_inject_duration, 28'(cyc - start_cyc)},
                        {mon_e.t, mon_e.s, mon_e.d, 28'(mon_e.c)});
        end
      end
      if (o_seq_done) done_q.push_back(cyc - start_cyc);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int r);
    int k = 0;
    while ((cyc - start_cyc) < r && k < 5000) begin
      step;
      k++;
    end
  endtask

  task automatic wr(input int idx, input logic [3:0] t, input logic [15:0] s,
                    input logic [15:0] d, input logic [15:0] g, input bit upd);
    i_tbl_wr_en = 1'b1; i_tbl_wr_idx = 3'(idx); i_tbl_wr_type = t;
    i_tbl_wr_sites = s; i_tbl_wr_duration = d; i_tbl_wr_gap = g;
    step;
    i_tbl_wr_en = 1'b0;
    if (upd) begin
      m_type[idx] = t; m_sites[idx] = s; m_dur[idx] = d; m_gap[idx] = g;
    end
  endtask

  // Campaign model: each entry costs ISSUE + WAIT_ACK + duration + gap cycles,
  // or a single cycle when its duration is zero. Returns the seq_done cycle.
  function automatic int build(input int num, input int loops);
    int t = 1;
    exp_t e;
    for (int l = 0; l < loops; l++) begin
      for (int i = 0; i < num; i++) begin
        if (m_dur[i] == 16'd0) begin
          t += 1;
        end else begin
          e.t = m_type[i]; e.s = m_sites[i]; e.d = m_dur[i]; e.c = t;
          exp_q.push_back(e);
          t += 2 + int'(m_dur[i]) + int'(m_gap[i]);
        end
      end
    end
    return t;
  endfunction

  task automatic start(input int num, input int loops);
    done_q.delete();
    i_seq_num_entries = 4'(num);
    i_seq_loop_count = 8'(loops);
    i_seq_start = 1'b1;
    start_cyc = cyc;
    step;
    i_seq_start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int exp_done, input int loops);
    int k = 0;
    while (o_seq_busy && k < 3000) begin
      step;
      k++;
    end
    chk({tag, "_timeout"}, 64'(k < 3000), 64'd1);
    chk({tag, "_ndone"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) chk({tag, "_done_cyc"}, 64'(done_q[0]), 64'(exp_done));
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_loops"}, 64'(o_loops_done), 64'(loops));
    chk({tag, "_err"}, 64'(o_seq_error), 64'd0);
  endtask

  int ed;
  int num_r, loops_r;

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_type[i] = '0; m_sites[i] = '0; m_dur[i] = '0; m_gap[i] = '0;
    end
    // Reset state
    repeat (3) step;
    chk("reset_outs", {o_seq_busy, o_inject_enable, o_seq_done, o_seq_error, o_inject_type,
                       o_inject_site_sel, o_inject_duration, o_cur_entry, o_loops_done}, 64'd0);
    rst_n = 1'b1;
    step;
    chk("post_reset_busy", 64'(o_seq_busy), 64'd0);

    // Scenario 1: basic two-entry sequence
    wr(0, 4'd1, 16'h0003, 16'd4, 16'd2, 1'b1);
    wr(1, 4'd0, 16'h0001, 16'd1, 16'd0, 1'b1);
    ed = build(2, 1);
    chk("s1_model_done", 64'(ed), 64'd12);
    start(2, 1);
    begin
      bit ok = 1'b1;
      for (int r = 1; r <= 6; r++) begin
        if ({o_inject_type, o_inject_site_sel, o_inject_duration} !== {4'd1, 16'h0003, 16'd4})
          ok = 1'b0;
        step;
      end
      chk("s1_hold", 64'(ok), 64'd1);
    end
    finish_run("s1", ed, 1);

    // Scenario 2: looping a single entry
    wr(0, 4'd3, 16'h00F0, 16'd3, 16'd0, 1'b1);
    ed = build(1, 3);
    start(1, 3);
    finish_run("s2", ed, 3);

    // Scenario 3: zero-duration entry skipped
    wr(0, 4'd2, 16'h0004, 16'd0, 16'd3, 1'b1);
    wr(1, 4'd1, 16'h0030, 16'd2, 16'd0, 1'b1);
    ed = build(2, 1);
    start(2, 1);
    finish_run("s3", ed, 1);

    // Scenario 4: acknowledge timeout
    stuck = 1'b1;
    wr(0, 4'd2, 16'h00F0, 16'd5, 16'd0, 1'b1);
    ed = build(1, 1);
    start(1, 1);
    wait_rel(9);
    chk("s4_busy_at9", {63'd0, o_seq_busy, o_seq_error}, 64'd2);
    step;
    chk("s4_idle_err", {o_seq_busy, o_seq_error, o_inject_type, o_inject_site_sel,
                        o_inject_duration, o_cur_entry}, {1'b0, 1'b1, 39'd0});
    chk("s4_no_done", 64'(done_q.size()), 64'd0);
    chk("s4_pending", 64'(exp_q.size()), 64'd0);
    stuck = 1'b0;
    ed = build(1, 1);
    start(1, 1);
    chk("s4_err_cleared", 64'(o_seq_error), 64'd0);
    finish_run("s4b", ed, 1);

    // Scenario 5a: stop during the gap
    wr(0, 4'd3, 16'h0100, 16'd2, 16'd10, 1'b1);
    ed = build(1, 1);
    start(1, 1);
    wait_rel(6);
    i_seq_stop = 1'b1;
    step;
    i_seq_stop = 1'b0;
    chk("s5a_busy", 64'(o_seq_busy), 64'd0);
    repeat (4) step;
    chk("s5a_no_done", 64'(done_q.size()), 64'd0);
    chk("s5a_pending", 64'(exp_q.size()), 64'd0);

    // Scenario 5b: stop while the injection is in flight
    wr(0, 4'd1, 16'h8000, 16'd20, 16'd0, 1'b1);
    wr(1, 4'd0, 16'h0001, 16'd3, 16'd0, 1'b1);
    ed = build(1, 1);
    start(2, 1);
    wait_rel(5);
    i_seq_stop = 1'b1;
    step;
    i_seq_stop = 1'b0;
    wait_rel(22);
    chk("s5b_busy_drain", {62'd0, o_seq_busy, i_inject_active}, 64'd2);
    step;
    chk("s5b_busy_end", 64'(o_seq_busy), 64'd0);
    repeat (4) step;
    chk("s5b_no_done", 64'(done_q.size()), 64'd0);
    chk("s5b_pending", 64'(exp_q.size()), 64'd0);

    // Scenario 6: illegal starts
    start(0, 1);
    chk("s6_num0", {62'd0, o_seq_busy, o_seq_error}, 64'd1);
    wr(0, 4'd0, 16'h0000, 16'd0, 16'd0, 1'b1);
    start(9, 1);
    chk("s6_num9", {62'd0, o_seq_busy, o_seq_error}, 64'd1);
    i_seq_stop = 1'b1;
    start(1, 1);
    i_seq_stop = 1'b0;
    chk("s6_stop_wins", 64'(o_seq_busy), 64'd0);

    // Start and table write while busy are both ignored
    wr(0, 4'd5, 16'h0A0A, 16'd3, 16'd0, 1'b1);
    ed = build(1, 1);
    start(1, 1);
    i_seq_start = 1'b1; i_seq_num_entries = 4'd2; i_seq_loop_count = 8'd5;
    i_tbl_wr_en = 1'b1; i_tbl_wr_idx = 3'd0; i_tbl_wr_type = 4'd7; i_tbl_wr_duration = 16'd9;
    step;
    i_seq_start = 1'b0; i_tbl_wr_en = 1'b0;
    finish_run("s6_busy", ed, 1);
    ed = build(1, 1);
    start(1, 1);
    finish_run("s6_tbl_kept", ed, 1);

    // Same-cycle write and start: start runs on the old contents
    ed = build(1, 1);
    i_tbl_wr_en = 1'b1; i_tbl_wr_idx = 3'd0; i_tbl_wr_type = 4'd6;
    i_tbl_wr_sites = 16'h0C0C; i_tbl_wr_duration = 16'd2; i_tbl_wr_gap = 16'd1;
    start(1, 1);
    i_tbl_wr_en = 1'b0;
    m_type[0] = 4'd6; m_sites[0] = 16'h0C0C; m_dur[0] = 16'd2; m_gap[0] = 16'd1;
    finish_run("s6_wr_start", ed, 1);
    ed = build(1, 1);
    start(1, 1);
    finish_run("s6_wr_new", ed, 1);

    // Asynchronous reset during WAIT_END
    wr(0, 4'd4, 16'h1111, 16'd20, 16'd0, 1'b1);
    ed = build(1, 1);
    start(1, 1);
    wait_rel(5);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_async_rst", {o_seq_busy, o_inject_enable, o_seq_done, o_seq_error, o_inject_type,
                         o_inject_site_sel, o_inject_duration, o_cur_entry, o_loops_done}, 64'd0);
    chk("s6_rst_pending", 64'(exp_q.size()), 64'd0);
    step;
    step;
    rst_n = 1'b1;
    step;
    for (int i = 0; i < 8; i++) begin
      m_type[i] = '0; m_sites[i] = '0; m_dur[i] = '0; m_gap[i] = '0;
    end
    ed = build(1, 1);
    start(1, 1);
    finish_run("s6_tbl_cleared", ed, 1);

    // Randomized campaigns
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 8; i++)
        wr(i, 4'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(0, 6)),
           16'($urandom_range(0, 4)), 1'b1);
      num_r = int'($urandom_range(1, 8));
      loops_r = int'($urandom_range(1, 3));
      ed = build(num_r, loops_r);
      start(num_r, loops_r);
      finish_run($sformatf("rand%0d", it), ed, loops_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/error_inject_sequencer.md
Name: error_inject_sequencer

Overview:
- Programmable campaign sequencer that drives the control port of the error injection controller (inject_enable, inject_type, inject_site_sel, inject_duration).
- Holds a table of injection entries, each with type, site mask, duration and inter-injection gap, and replays them in order for a configurable number of loops.
- Handshakes with the injector's inject_active status so only one injection is in flight at a time.
- Sits between the testbench/config host and the injector.

Parameters:
- NUM_ENTRIES, 8: campaign table depth (power of two, ≥2).
- NUM_INJECT_SITES, 16: site mask width; must match the injector.
- ACK_TIMEOUT, 8: maximum cycles in WAIT_ACK before a timeout error.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- tbl_wr_en  in  1  table write strobe.
- tbl_wr_idx  in  $clog2(NUM_ENTRIES)  table entry index.
- tbl_wr_type  in  4  entry error type (0=ECC, 1=CRC, 2=Parity, 3=Multi-bit).
- tbl_wr_sites  in  NUM_INJECT_SITES  entry site mask.
- tbl_wr_duration  in  16  entry injection duration in cycles.
- tbl_wr_gap  in  16  idle cycles after the injection ends.
- seq_start  in  1  start pulse.
- seq_stop  in  1  stop request.
- seq_num_entries  in  $clog2(NUM_ENTRIES)+1  entries per loop; sampled on start.
- seq_loop_count  in  8  loops to run; 0 = run until stopped; sampled on start.
- inject_active  in  1  injector busy status.
- inject_enable  out  1  one-cycle issue pulse to the injector.
- inject_type  out  4  current entry type.
- inject_site_sel  out  NUM_INJECT_SITES  current entry site mask.
- inject_duration  out  16  current entry duration.
- seq_busy  out  1  high in any state other than IDLE.
- seq_done  out  1  one-cycle pulse on normal completion.
- seq_error  out  1  sticky error flag.
- cur_entry  out  $clog2(NUM_ENTRIES)  index of the entry in progress.
- loops_done  out  8  completed loops; saturates at 255.

Behaviour:
- Reset values (asynchronous): state IDLE; all outputs 0; table contents 0.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_END, GAP, DONE.
- IDLE, seq_start=1:
  - seq_num_entries==0 or >NUM_ENTRIES → set seq_error, remain in IDLE.
  - Otherwise: clear seq_error, loops_done and cur_entry; latch num_entries and loop_count; load entry 0; go to ISSUE.
- Entry load: inject_type, inject_site_sel and inject_duration are registered from the table and held stable from ISSUE through WAIT_END. They are zeroed in IDLE.
- ISSUE:
  - inject_enable=1 for exactly this one cycle.
  - Next state WAIT_ACK.
  - If entry duration==0: no pulse is issued; go directly to the next-entry decision.
- WAIT_ACK:
  - inject_active=1 → WAIT_END.
  - Timeout counter reaches ACK_TIMEOUT cycles without inject_active → set seq_error, go to IDLE, zero outputs.
- WAIT_END: inject_active=0 → GAP if gap>0, otherwise the next-entry decision.
- GAP: stays exactly gap cycles (16-bit down-counter), then the next-entry decision.
- Next-entry decision:
  - cur_entry<num_entries-1 → increment cur_entry, load entry, go to ISSUE.
  - Otherwise → loops_done+1 (saturating) and cur_entry=0.
    - If loop_count≠0 and the new loops_done==loop_count → DONE.
    - Otherwise → ISSUE with entry 0.
- DONE: seq_done=1 for one cycle, then IDLE.
- seq_stop:
  - In GAP or ISSUE (before the pulse) → IDLE on the next cycle.
  - In WAIT_ACK or WAIT_END → stop is latched; the in-flight injection completes (inject_active low, or timeout), then IDLE.
  - No seq_done is raised on a stop.
- seq_start while busy: ignored.
- Simultaneous start and stop in IDLE: stop wins, no start.
- Table writes:
  - Accepted only in IDLE; ignored while busy.
  - A write and a start in the same cycle: the start uses the old table contents.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. The injector is not otherwise notified.

Test Plan:
- Setup for all scenarios: injector model asserts inject_active from 1 cycle after enable, for duration cycles.
- Scenario 1, basic sequence:
  - e0 = {type 1, sites 0x0003, dur 4, gap 2}, e1 = {type 0, sites 0x0001, dur 1, gap 0}, num 2, loops 1; start sampled at cycle 0.
  - Required: inject_enable at cycles 1 and 9; type 1/0x0003/4 held during cycles 1–6; seq_done at cycle 12; loops_done=1.
- Scenario 2, looping:
  - 1 entry (dur 3, gap 0), loops 3.
  - Required: exactly 3 enable pulses, one seq_done, loops_done=3.
- Scenario 3, zero-duration skip:
  - e0 dur 0, e1 dur 2, num 2, loops 1.
  - Required: only one enable pulse (e1, type/sites of e1); seq_done asserted.
- Scenario 4, ack timeout:
  - Injector model holds inject_active=0.
  - Required: seq_error=1 after 8 WAIT_ACK cycles, state IDLE, all inject_* = 0, no seq_done.
  - A following valid start clears seq_error.
- Scenario 5, stop handling:
  - Stop in GAP (gap 10) → seq_busy=0 on the next cycle.
  - Stop in WAIT_END (dur 20) → seq_busy stays high until inject_active falls, then 0.
  - No seq_done in either case.
- Scenario 6, illegal starts and reset:
  - seq_num_entries=0 → seq_error, stays IDLE.
  - Start while busy → no effect.
  - rst_n low during WAIT_END → all outputs 0 asynchronously.
